// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus widths, owner tags and the response-tag record
// used by the unified-memory arbiter.
`default_nettype none

package mem_arbiter_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  typedef enum logic [0:0] {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWNER_INST};

  function automatic tag_t make_tag(input logic valid, input owner_e owner);
    tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_tag_pipe.sv
// mem_arbiter_tag_pipe: MEM_LATENCY-deep {valid, owner} shift register that
// tracks which port owns each read response; cleared asynchronously.
`default_nettype none

module mem_arbiter_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [MEM_LATENCY];

  // Latency is fixed by the memory, so the pipe shifts every cycle unconditionally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[MEM_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined synchronous memory port between fetch (I)
// and load/store (D); data has priority, a starvation counter protects fetch.
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_BUS,
  parameter int DATA_WIDTH   = DATA_BUS,
  parameter int SEL_WIDTH    = MEM_SEL_BUS,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_req,
  input  logic [SEL_WIDTH-1:0]  inst_write_en,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [DATA_WIDTH-1:0] inst_write_data,
  output logic                  inst_ready,
  output logic                  inst_rvalid,
  output logic [DATA_WIDTH-1:0] inst_read_data,

  input  logic                  data_req,
  input  logic [SEL_WIDTH-1:0]  data_write_en,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_write_data,
  output logic                  data_ready,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_read_data,

  output logic                  mem_en,
  output logic [SEL_WIDTH-1:0]  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             inst_starved;
  logic             inst_win;
  logic             data_win;
  logic             read_accepted;
  tag_t             tag_in;
  tag_t             tag_out;

  // Grants are gated by rst so every combinational output drops the moment
  // reset asserts, without waiting for a clock edge.
  always_comb begin
    inst_starved = (starve_cnt_q == CNT_MAX);
    inst_win     = rst && inst_req && (!data_req || inst_starved);
    data_win     = rst && data_req && !inst_win;
  end

  assign inst_ready = inst_win;
  assign data_ready = data_win;

  always_comb begin
    mem_en         = 1'b0;
    mem_write_en   = '0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (data_win) begin
      mem_en         = 1'b1;
      mem_write_en   = data_write_en;
      mem_addr       = data_addr;
      mem_write_data = data_write_data;
    end else if (inst_win) begin
      mem_en         = 1'b1;
      mem_write_en   = inst_write_en;
      mem_addr       = inst_addr;
      mem_write_data = inst_write_data;
    end
  end

  always_comb begin
    read_accepted = (data_win && (data_write_en == '0)) ||
                    (inst_win && (inst_write_en == '0));
    tag_in        = make_tag(read_accepted, data_win ? OWNER_DATA : OWNER_INST);
  end

  mem_arbiter_tag_pipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    inst_rvalid    = tag_out.valid && (tag_out.owner == OWNER_INST);
    data_rvalid    = tag_out.valid && (tag_out.owner == OWNER_DATA);
    inst_read_data = inst_rvalid ? mem_read_data : '0;
    data_read_data = data_rvalid ? mem_read_data : '0;
  end

  // Counts consecutive cycles fetch asked and was refused; any fetch grant
  // or idle fetch cycle clears it.
  always_comb begin
    starve_cnt_d = '0;
    if (inst_req && !inst_win) begin
      starve_cnt_d = inst_starved ? CNT_MAX : starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

`default_nettype wire
